// File: rtl/axis_stream_receiver.sv
// AXI4-Stream receiver: FWFT beat FIFO with TREADY backpressure, per-packet
// aligned/unaligned/sparse classification, saturating class counters, stability checker.
module axis_stream_receiver #(
    parameter int DATA_BYTES = 4,
    parameter int DEPTH      = 8,
    parameter int ID_W       = 4,
    parameter int DEST_W     = 4,
    parameter int CNT_W      = 16
) (
    input  logic                                                 ACLK,
    input  logic                                                 ARESETn,
    input  logic                                                 TVALID,
    output logic                                                 TREADY,
    input  logic [8*DATA_BYTES-1:0]                              TDATA,
    input  logic [DATA_BYTES-1:0]                                TSTRB,
    input  logic [DATA_BYTES-1:0]                                TKEEP,
    input  logic                                                 TLAST,
    input  logic [ID_W-1:0]                                      TID,
    input  logic [DEST_W-1:0]                                    TDEST,
    input  logic                                                 rd_en,
    output logic                                                 rd_valid,
    output logic [8*DATA_BYTES+2*DATA_BYTES+1+ID_W+DEST_W-1:0]   rd_data,
    output logic                                                 pkt_done,
    output logic [1:0]                                           pkt_class,
    output logic [CNT_W-1:0]                                     aligned_cnt,
    output logic [CNT_W-1:0]                                     unaligned_cnt,
    output logic [CNT_W-1:0]                                     sparse_cnt,
    output logic                                                 proto_err
);
    localparam int ENTRY_W = 8*DATA_BYTES + 2*DATA_BYTES + 1 + ID_W + DEST_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]        FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [DATA_BYTES-1:0] ONE_B      = DATA_BYTES'(1);
    localparam logic [CNT_W-1:0]      ONE_C      = CNT_W'(1);

    typedef enum logic {IDLE, IN_PKT} state_t;

    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count;
    logic                  ready_en;
    logic                  push, pop;
    logic [ENTRY_W-1:0]    beat;

    state_t                state, state_nxt;
    logic                  sparse_r, partial_r;
    logic [DATA_BYTES-1:0] m;
    logic                  beat_full, beat_sparse, acc_sparse, acc_partial, emit;
    logic [1:0]            cls_nxt;

    logic                  stall_p1;
    logic [ENTRY_W-1:0]    held_p1;

    // Ones form a single run starting at bit 0 (zero also passes; callers exclude it).
    function automatic logic low_run(input logic [DATA_BYTES-1:0] v);
        logic [DATA_BYTES-1:0] t;
        t = v + ONE_B;
        return (v & t) == '0;
    endfunction

    function automatic logic is_lo(input logic [DATA_BYTES-1:0] v);
        return (v != '0) && low_run(v);
    endfunction

    function automatic logic is_hi(input logic [DATA_BYTES-1:0] v);
        return (v != '0) && low_run(~v);
    endfunction

    function automatic logic is_contig(input logic [DATA_BYTES-1:0] v);
        logic [DATA_BYTES-1:0] f;
        f = v | (v - ONE_B);
        return (v != '0) && low_run(f);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + ONE_C;
    endfunction

    assign beat     = {TDEST, TID, TLAST, TKEEP, TSTRB, TDATA};
    assign TREADY   = ready_en && (count != FULL_COUNT);
    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];
    assign push     = TVALID && TREADY;
    assign pop      = rd_en && rd_valid;

    // FIFO control
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ready_en <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr] <= beat;
    end

    always_comb begin
        state_nxt   = state;
        m           = TKEEP & TSTRB;
        beat_full   = &m;
        beat_sparse = 1'b0;
        if (state == IDLE && TLAST)       beat_sparse = !is_contig(m);
        else if (state == IDLE)           beat_sparse = !(beat_full || is_hi(m));
        else if (TLAST)                   beat_sparse = !(beat_full || is_lo(m));
        else                              beat_sparse = !beat_full;
        if (TKEEP == '0) beat_sparse = 1'b1;
        // Flags restart with the first beat of every packet.
        acc_sparse  = ((state == IDLE) ? 1'b0 : sparse_r)  | beat_sparse;
        acc_partial = ((state == IDLE) ? 1'b0 : partial_r) | !beat_full;
        cls_nxt     = acc_sparse ? 2'b10 : (acc_partial ? 2'b01 : 2'b00);
        emit        = push && TLAST;
        if (push) state_nxt = TLAST ? IDLE : IN_PKT;
    end

    // Classification result and counters
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state         <= IDLE;
            sparse_r      <= 1'b0;
            partial_r     <= 1'b0;
            pkt_done      <= 1'b0;
            pkt_class     <= 2'b00;
            aligned_cnt   <= '0;
            unaligned_cnt <= '0;
            sparse_cnt    <= '0;
        end else begin
            state    <= state_nxt;
            pkt_done <= emit;
            if (push) begin
                sparse_r  <= acc_sparse;
                partial_r <= acc_partial;
            end
            if (emit) begin
                pkt_class <= cls_nxt;
                case (cls_nxt)
                    2'b00:   aligned_cnt   <= sat_inc(aligned_cnt);
                    2'b01:   unaligned_cnt <= sat_inc(unaligned_cnt);
                    default: sparse_cnt    <= sat_inc(sparse_cnt);
                endcase
            end
        end
    end

    // Stability checker: a stalled beat must be held unchanged until accepted
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            stall_p1  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            stall_p1 <= TVALID && !TREADY;
            if (stall_p1 && (!TVALID || beat != held_p1)) proto_err <= 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        held_p1 <= beat;
    end
endmodule
